// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared pipeline control encodings and helpers
package pipeline_ctrl_pkg;

    // Sequencing controller state encoding
    localparam logic ST_RUN    = 1'b0;
    localparam logic ST_MULDIV = 1'b1;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Forward-select codes shared with the EX-stage forwarding logic
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // A producer hits a consumer only when it names the same non-zero register.
    function automatic logic reg_hit(input logic [4:0] producer, input logic [4:0] consumer);
        return (producer != REG_ZERO) && (producer == consumer);
    endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// rtl/hazard_stall_controller_if.sv - hazard inputs and pipeline control outputs
// master: pipeline side (drives hazard information, consumes controls)
// slave : hazard_stall_controller (consumes hazard information, drives controls)
interface hazard_stall_controller_if #(
    parameter int PERF_WIDTH = 32
);
    logic [4:0]            IF_ID_RegisterRs;
    logic [4:0]            IF_ID_RegisterRt;
    logic                  IF_ID_UsesRt;
    logic                  ID_Branch;
    logic                  ID_BranchTaken;
    logic                  ID_Jump;
    logic [4:0]            ID_EX_RegisterRd;
    logic                  ID_EX_RegWrite;
    logic                  ID_EX_MemRead;
    logic                  ID_EX_MulDiv;
    logic [4:0]            EX_MEM_RegisterRd;
    logic                  EX_MEM_MemRead;
    logic                  PCWrite;
    logic                  IF_ID_Write;
    logic                  IF_ID_Flush;
    logic                  ID_EX_Write;
    logic                  ID_EX_Flush;
    logic                  EX_MEM_Flush;
    logic                  MulDivBusy;
    logic                  MulDivDone;
    logic [PERF_WIDTH-1:0] StallCount;

    modport master (
        output IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_UsesRt, ID_Branch, ID_BranchTaken,
               ID_Jump, ID_EX_RegisterRd, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MulDiv,
               EX_MEM_RegisterRd, EX_MEM_MemRead,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Flush,
               MulDivBusy, MulDivDone, StallCount
    );

    modport slave (
        input  IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_UsesRt, ID_Branch, ID_BranchTaken,
               ID_Jump, ID_EX_RegisterRd, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MulDiv,
               EX_MEM_RegisterRd, EX_MEM_MemRead,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Flush,
               MulDivBusy, MulDivDone, StallCount
    );

endinterface

// File: rtl/stall_perf_counter.sv
// rtl/stall_perf_counter.sv - saturating event counter
// clk/reset : clock, synchronous active-high clear
// en        : count this cycle
// count     : saturates at all-ones
module stall_perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use/branch stalls, flushes and mult/div freeze
// clk/reset : core clock, synchronous active-high reset
// hs        : hazard inputs from ID/EX/MEM, PC and pipeline-register write/flush controls,
//             mult/div status and the stall-cycle counter
module hazard_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4,
    parameter int PERF_WIDTH     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    hazard_stall_controller_if.slave hs
);

    logic       state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       done_hold_q, done_hold_d;

    logic load_use, br_ex, br_mem, data_stall, mstart, freeze, last_cycle;
    logic pc_write;

    always_comb begin
        load_use = hs.ID_EX_MemRead &&
                   (reg_hit(hs.ID_EX_RegisterRd, hs.IF_ID_RegisterRs) ||
                    (hs.IF_ID_UsesRt && reg_hit(hs.ID_EX_RegisterRd, hs.IF_ID_RegisterRt)));
        // An ALU or load result in EX cannot reach the ID comparator in time.
        br_ex = hs.ID_Branch && hs.ID_EX_RegWrite &&
                (reg_hit(hs.ID_EX_RegisterRd, hs.IF_ID_RegisterRs) ||
                 reg_hit(hs.ID_EX_RegisterRd, hs.IF_ID_RegisterRt));
        // A load in MEM has no data until WB, so the branch waits one more cycle.
        br_mem = hs.ID_Branch && hs.EX_MEM_MemRead &&
                 (reg_hit(hs.EX_MEM_RegisterRd, hs.IF_ID_RegisterRs) ||
                  reg_hit(hs.EX_MEM_RegisterRd, hs.IF_ID_RegisterRt));
        data_stall = load_use || br_ex || br_mem;
        // done_hold masks the completed op, which is still sitting in EX for one cycle.
        mstart     = (state_q == ST_RUN) && hs.ID_EX_MulDiv && !done_hold_q;
        freeze     = (state_q == ST_MULDIV) || mstart;
        last_cycle = (state_q == ST_MULDIV) && (cnt_q == 4'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= 4'd0;
            done_hold_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_hold_q <= done_hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_hold_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mstart) begin
                    state_d = ST_MULDIV;
                    cnt_d   = 4'(MULDIV_LATENCY - 1);
                end
            end
            default: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d     = ST_RUN;
                    done_hold_d = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        pc_write        = 1'b1;
        hs.IF_ID_Write  = 1'b1;
        hs.IF_ID_Flush  = 1'b0;
        hs.ID_EX_Write  = 1'b1;
        hs.ID_EX_Flush  = 1'b0;
        hs.EX_MEM_Flush = 1'b0;
        hs.MulDivBusy   = 1'b0;
        hs.MulDivDone   = 1'b0;
        if (!reset) begin
            hs.MulDivBusy = (state_q == ST_MULDIV);
            hs.MulDivDone = last_cycle;
            if (freeze) begin
                // Hold everything upstream of EX; the op drains a bubble into MEM.
                pc_write        = 1'b0;
                hs.IF_ID_Write  = 1'b0;
                hs.ID_EX_Write  = 1'b0;
                hs.EX_MEM_Flush = 1'b1;
            end else if (data_stall) begin
                pc_write       = 1'b0;
                hs.IF_ID_Write = 1'b0;
                hs.ID_EX_Flush = 1'b1;
            end else if ((hs.ID_Branch && hs.ID_BranchTaken) || hs.ID_Jump) begin
                hs.IF_ID_Flush = 1'b1;
            end
        end
    end

    assign hs.PCWrite = pc_write;

    stall_perf_counter #(
        .WIDTH (PERF_WIDTH)
    ) u_stall_perf_counter (
        .clk   (clk),
        .reset (reset),
        .en    (~pc_write),
        .count (hs.StallCount)
    );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - bench for hazard_stall_controller
module tb_hazard_stall_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_stall_controller_if #(.PERF_WIDTH(4)) bus ();

    hazard_stall_controller #(
        .MULDIV_LATENCY (4),
        .PERF_WIDTH     (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hs    (bus)
    );

    typedef struct {
        string      name;
        logic [4:0] rs, rt;
        logic       uses_rt, br, taken, jump;
        logic [4:0] ex_rd;
        logic       ex_rw, ex_mr;
        logic [4:0] mem_rd;
        logic       mem_mr;
        logic [5:0] exp;   // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Flush}
    } vec_t;

    localparam logic [5:0] C_RUN    = 6'b110100;
    localparam logic [5:0] C_STALL  = 6'b000110;
    localparam logic [5:0] C_FLUSH  = 6'b111100;
    localparam logic [5:0] C_FREEZE = 6'b000001;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] model_cnt;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [5:0] ctl();
        return {bus.PCWrite, bus.IF_ID_Write, bus.IF_ID_Flush,
                bus.ID_EX_Write, bus.ID_EX_Flush, bus.EX_MEM_Flush};
    endfunction

    task automatic clear_inputs();
        bus.IF_ID_RegisterRs  = 5'd0;
        bus.IF_ID_RegisterRt  = 5'd0;
        bus.IF_ID_UsesRt      = 1'b0;
        bus.ID_Branch         = 1'b0;
        bus.ID_BranchTaken    = 1'b0;
        bus.ID_Jump           = 1'b0;
        bus.ID_EX_RegisterRd  = 5'd0;
        bus.ID_EX_RegWrite    = 1'b0;
        bus.ID_EX_MemRead     = 1'b0;
        bus.ID_EX_MulDiv      = 1'b0;
        bus.EX_MEM_RegisterRd = 5'd0;
        bus.EX_MEM_MemRead    = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        bus.IF_ID_RegisterRs  = v.rs;
        bus.IF_ID_RegisterRt  = v.rt;
        bus.IF_ID_UsesRt      = v.uses_rt;
        bus.ID_Branch         = v.br;
        bus.ID_BranchTaken    = v.taken;
        bus.ID_Jump           = v.jump;
        bus.ID_EX_RegisterRd  = v.ex_rd;
        bus.ID_EX_RegWrite    = v.ex_rw;
        bus.ID_EX_MemRead     = v.ex_mr;
        bus.ID_EX_MulDiv      = 1'b0;
        bus.EX_MEM_RegisterRd = v.mem_rd;
        bus.EX_MEM_MemRead    = v.mem_mr;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        //          name           rs  rt  ur br tk jp exrd rw mr  mrd mmr exp
        vecs[0]  = '{"lw_rs",       8,  3, 1, 0, 0, 0,  8,  1, 1,  0, 0, C_STALL};
        vecs[1]  = '{"lw_rt_unused",2,  8, 0, 0, 0, 0,  8,  1, 1,  0, 0, C_RUN};
        vecs[2]  = '{"lw_rt_used",  2,  8, 1, 0, 0, 0,  8,  1, 1,  0, 0, C_STALL};
        vecs[3]  = '{"lw_rd0",      0,  0, 1, 0, 0, 0,  0,  1, 1,  0, 0, C_RUN};
        vecs[4]  = '{"br_no_rw",    4,  6, 1, 1, 0, 0,  4,  0, 0,  0, 0, C_RUN};
        vecs[5]  = '{"br_ex_taken", 7,  5, 1, 1, 1, 0,  5,  1, 0,  0, 0, C_STALL};
        vecs[6]  = '{"br_mem",      9,  1, 1, 1, 0, 0,  3,  1, 0,  9, 1, C_STALL};
        vecs[7]  = '{"br_mem_rd0",  0,  1, 1, 1, 0, 0,  3,  1, 0,  0, 1, C_RUN};
        vecs[8]  = '{"br_taken",    2,  3, 1, 1, 1, 0,  4,  1, 0,  5, 1, C_FLUSH};
        vecs[9]  = '{"jump",        2,  3, 0, 0, 0, 1,  0,  0, 0,  0, 0, C_FLUSH};
        vecs[10] = '{"br_not_taken",2,  3, 1, 1, 0, 0,  4,  1, 0,  5, 1, C_RUN};
        vecs[11] = '{"mem_ld_nobr", 9,  9, 1, 0, 0, 0,  3,  1, 0,  9, 1, C_RUN};

        // Reset forces the run controls even with a hazard presented.
        reset = 1'b1;
        apply(vecs[0]);
        bus.ID_EX_MulDiv = 1'b1;
        @(negedge clk);
        chk("reset_ctl", 32'(ctl()), 32'(C_RUN));
        chk("reset_busy", 32'(bus.MulDivBusy), 0);
        cycle();
        chk("reset_cnt", 32'(bus.StallCount), 0);
        do_reset();

        // Single-cycle decode table from RUN.
        model_cnt = 4'd0;
        foreach (vecs[i]) begin
            apply(vecs[i]);
            @(negedge clk);
            chk(vecs[i].name, 32'(ctl()), 32'(vecs[i].exp));
            if (vecs[i].exp[5] == 1'b0 && model_cnt != 4'hF) model_cnt++;
            cycle();
            chk({vecs[i].name, "_cnt"}, 32'(bus.StallCount), 32'(model_cnt));
        end

        // beq on a load result: stall in EX, stall again in MEM, then flush once.
        do_reset();
        bus.ID_Branch = 1'b1; bus.IF_ID_RegisterRs = 5'd9; bus.IF_ID_RegisterRt = 5'd2;
        bus.ID_EX_RegisterRd = 5'd9; bus.ID_EX_RegWrite = 1'b1; bus.ID_EX_MemRead = 1'b1;
        @(negedge clk); chk("brld_c1", 32'(ctl()), 32'(C_STALL));
        cycle();
        bus.ID_EX_RegisterRd = 5'd0; bus.ID_EX_RegWrite = 1'b0; bus.ID_EX_MemRead = 1'b0;
        bus.EX_MEM_RegisterRd = 5'd9; bus.EX_MEM_MemRead = 1'b1; bus.ID_BranchTaken = 1'b1;
        @(negedge clk); chk("brld_c2", 32'(ctl()), 32'(C_STALL));
        cycle();
        bus.EX_MEM_RegisterRd = 5'd0; bus.EX_MEM_MemRead = 1'b0;
        @(negedge clk); chk("brld_c3_flush", 32'(ctl()), 32'(C_FLUSH));
        cycle();
        clear_inputs();
        @(negedge clk); chk("brld_c4", 32'(ctl()), 32'(C_RUN));
        cycle();
        chk("brld_cnt", 32'(bus.StallCount), 2);

        // mult/div freeze, with a coincident br_mem stall that must lose.
        do_reset();
        bus.ID_EX_MulDiv = 1'b1;
        bus.ID_Branch = 1'b1; bus.IF_ID_RegisterRs = 5'd9;
        bus.EX_MEM_RegisterRd = 5'd9; bus.EX_MEM_MemRead = 1'b1;
        @(negedge clk);
        chk("md_t0", 32'(ctl()), 32'(C_FREEZE));
        chk("md_t0_busy", 32'(bus.MulDivBusy), 0);
        chk("md_t0_done", 32'(bus.MulDivDone), 0);
        cycle();
        bus.ID_Branch = 1'b0; bus.EX_MEM_MemRead = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("md_t%0d", k), 32'(ctl()), 32'(C_FREEZE));
            chk($sformatf("md_t%0d_busy", k), 32'(bus.MulDivBusy), 1);
            chk($sformatf("md_t%0d_done", k), 32'(bus.MulDivDone), (k == 3) ? 1 : 0);
            cycle();
        end
        @(negedge clk);
        chk("md_t4_noretrig", 32'(ctl()), 32'(C_RUN));
        chk("md_t4_busy", 32'(bus.MulDivBusy), 0);
        cycle();
        chk("md_cnt", 32'(bus.StallCount), 4);
        @(negedge clk);
        chk("md_back2back", 32'(ctl()), 32'(C_FREEZE));

        // Reset in the middle of a freeze.
        do_reset();
        bus.ID_EX_MulDiv = 1'b1;
        cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("mdrst_t1_ctl", 32'(ctl()), 32'(C_RUN));
        chk("mdrst_t1_busy", 32'(bus.MulDivBusy), 0);
        cycle();
        reset = 1'b0;
        bus.ID_EX_MulDiv = 1'b0;
        @(negedge clk);
        chk("mdrst_t2_ctl", 32'(ctl()), 32'(C_RUN));
        chk("mdrst_t2_busy", 32'(bus.MulDivBusy), 0);
        cycle();
        chk("mdrst_cnt", 32'(bus.StallCount), 0);

        // Counter saturation with a 4-bit counter.
        do_reset();
        apply(vecs[0]);
        for (int k = 1; k <= 20; k++) begin
            cycle();
            chk($sformatf("sat_%0d", k), 32'(bus.StallCount), (k > 15) ? 15 : k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Sits beside the EX-stage forwarding logic and handles the hazards forwarding cannot resolve:
  - load-use stalls,
  - branch-in-ID operand stalls,
  - taken-branch/jump flushes,
  - multi-cycle mult/div freezes.
- Drives the PC, IF/ID, ID/EX and EX/MEM write/flush controls and keeps a saturating stall-cycle performance counter.

Parameters:
- MULDIV_LATENCY, 4, total cycles the front pipeline is frozen per mult/div op; legal range 2..15.
- PERF_WIDTH, 32, width of the stall-cycle counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- IF_ID_RegisterRs  input  5  rs of instruction in ID
- IF_ID_RegisterRt  input  5  rt of instruction in ID
- IF_ID_UsesRt  input  1  ID instruction reads rt (R-type, store, branch)
- ID_Branch  input  1  ID holds beq/bne (compared in ID)
- ID_BranchTaken  input  1  branch comparison result in ID
- ID_Jump  input  1  ID holds j/jal/jr
- ID_EX_RegisterRd  input  5  destination of instruction in EX (already muxed rt/rd)
- ID_EX_RegWrite  input  1  EX instruction writes a register
- ID_EX_MemRead  input  1  EX instruction is a load
- ID_EX_MulDiv  input  1  EX instruction is mult/div
- EX_MEM_RegisterRd  input  5  destination in MEM
- EX_MEM_MemRead  input  1  MEM instruction is a load
- PCWrite  output  1  1 = PC updates
- IF_ID_Write  output  1  1 = IF/ID register loads
- IF_ID_Flush  output  1  1 = IF/ID loads a NOP
- ID_EX_Write  output  1  1 = ID/EX register loads
- ID_EX_Flush  output  1  1 = ID/EX loads a bubble (control zeroed)
- EX_MEM_Flush  output  1  1 = EX/MEM loads a bubble
- MulDivBusy  output  1  state is MULDIV
- MulDivDone  output  1  one-cycle pulse in last frozen cycle
- StallCount  output  PERF_WIDTH  saturating count of cycles with PCWrite=0

Behaviour:
- Registered state: state {RUN, MULDIV}, cnt[3:0], done_hold, StallCount. Control outputs are combinational decode of the registers and the current inputs.
- Reset (sync, any state including mid-MULDIV):
  - next state RUN, cnt=0, done_hold=0, StallCount=0.
  - While reset=1, outputs are forced to: PCWrite=1, IF_ID_Write=1, ID_EX_Write=1, all flushes=0, MulDivBusy=0, MulDivDone=0.
- Hazard terms (register 0 never matches):
  - load_use = ID_EX_MemRead && Rd!=0 && (Rd==IF_ID_RegisterRs || (IF_ID_UsesRt && Rd==IF_ID_RegisterRt)).
  - br_ex = ID_Branch && ID_EX_RegWrite && Rd!=0 && Rd matches ID rs or rt. This covers ALU and load producers: a load in EX stalls now, then again next cycle via br_mem.
  - br_mem = ID_Branch && EX_MEM_MemRead && EX_MEM_RegisterRd!=0 && matches ID rs or rt.
  - data_stall = load_use || br_ex || br_mem.
  - mstart = state==RUN && ID_EX_MulDiv && !done_hold.
- Priority, highest first:
  1. MULDIV state or mstart: PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Flush=1, IF_ID_Flush=0, ID_EX_Flush=0.
  2. data_stall: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, ID_EX_Write=1.
  3. (ID_Branch && ID_BranchTaken) || ID_Jump: IF_ID_Flush=1, all writes=1. A flush is never asserted in a stall cycle, because the branch is not yet resolved.
  4. Otherwise all writes=1, all flushes=0.
- MULDIV sequencing:
  - mstart cycle T: next state MULDIV, cnt<=MULDIV_LATENCY-1.
  - In MULDIV: cnt decrements each cycle. When cnt==1: MulDivDone=1, next state RUN, done_hold<=1.
  - Total frozen cycles = MULDIV_LATENCY (T plus LATENCY-1 MULDIV cycles).
  - done_hold clears unconditionally the following cycle. It prevents the same op, still in EX for one cycle, from retriggering.
  - Back-to-back mult/div ops each freeze independently.
  - ID_EX_MulDiv is ignored while in MULDIV.
- Simultaneous events:
  - mstart with data_stall: muldiv wins. The data stall is re-evaluated after release.
  - Taken branch with br_ex: stall, no flush.
- StallCount: +1 every cycle PCWrite=0 (reset excluded); holds at all-ones.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - state encoding localparams ST_RUN/ST_MULDIV,
  - REG_ZERO=5'd0,
  - the 2'b00/01/10 forward-select codes shared with the forwarding logic.
- One sub-module: stall_perf_counter (saturating PERF_WIDTH counter with sync reset, enable=~PCWrite).
- The rest stays flat.

Test Plan:
- lw $8 in EX (ID_EX_MemRead=1, Rd=8), ID reads rs=8 -> one cycle PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; StallCount 0->1.
- beq rs=9 in ID, lw Rd=9 in EX -> 2 stall cycles (br_ex, then br_mem with EX_MEM_Rd=9); then ID_BranchTaken=1 -> IF_ID_Flush=1 for exactly one cycle.
- Rd=0 load with ID rs=0, and ID_EX_RegWrite=0 branch match -> no stall, all writes=1.
- ID_EX_MulDiv=1 at T, MULDIV_LATENCY=4 -> freeze cycles T..T+3, MulDivDone only at T+3, RUN at T+4 with no retrigger; StallCount +4.
- reset=1 at T+1 of a muldiv freeze -> T+2 state RUN, all writes=1, MulDivBusy=0, StallCount=0.
- Saturation: PERF_WIDTH=4, hold 20 stall cycles -> StallCount stays 4'hF.
